// File: rtl/dyt_sram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// common_types
//   Shared types for the SRAM arbiter slice.
//   word_t      : 32-bit machine word used for addresses and data.
//   arb_state_t : arbiter FSM states (IDLE -> ACCESS -> [LATWAIT] -> RESP).
//   arb_port_t  : identifies which CPU port owns the current transaction.
// -----------------------------------------------------------------------------
package common_types;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_LATWAIT = 2'd2,
    ST_RESP    = 2'd3
  } arb_state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } arb_port_t;

  // Widest legal SRAM read latency; the latency counter is sized for it.
  localparam int RD_LAT_MAX = 3;

endpackage

// File: rtl/dyt_sram_arbiter.sv
// -----------------------------------------------------------------------------
// dyt_sram_arbiter
//   Shares one single-ported SRAM between an instruction-fetch port and a
//   data port. One transaction is in flight at a time. When both ports
//   request, data wins unless the previous completed grant was data, in which
//   case fetch wins, so the two ports alternate under contention.
//
// Parameters
//   RD_LAT        SRAM read latency (cycles from sram_ren to valid data), 1..3
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   iren/iaddr    fetch request (held until iwait low) and address
//   iwait/iload   fetch busy flag / fetch data (valid while iwait low)
//   dren/dwen     data read / write request (held until dwait low)
//   daddr/dstore  data address / write data
//   dwait/dload   data busy flag / read data (valid while dwait low)
//   sram_*        SRAM side: address, write data, read/write strobes, read data
//
// Latency: write = 2 cycles (IDLE, ACCESS); read = RD_LAT + 2 cycles
//   (IDLE, ACCESS, RD_LAT-1 x LATWAIT, RESP).
// -----------------------------------------------------------------------------
module dyt_sram_arbiter
  import common_types::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iren,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dren,
  input  logic        dwen,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic [31:0] sram_address,
  output logic [31:0] sram_w_data,
  output logic        sram_ren,
  output logic        sram_wen,
  input  logic [31:0] sram_r_data
);

  localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

  arb_state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  arb_port_t  port_q, port_d;
  arb_port_t  last_q, last_d;
  word_t      addr_q, addr_d;
  word_t      wdata_q, wdata_d;
  logic       we_q, we_d;

  logic      dreq;
  arb_port_t pick;

  // Either data strobe counts as a data request; dwen decides the direction.
  assign dreq = dren | dwen;

  // Data wins contention unless it also won the previous completed grant.
  always_comb begin
    pick = PORT_I;
    if (dreq && !(iren && last_q == PORT_D)) pick = PORT_D;
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      port_q  <= PORT_I;
      last_q  <= PORT_I;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      port_q  <= port_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    port_d  = port_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    unique case (state_q)
      ST_IDLE: begin
        if (iren || dreq) begin
          port_d  = pick;
          addr_d  = (pick == PORT_D) ? daddr : iaddr;
          wdata_d = (pick == PORT_D) ? dstore : '0;
          // dren+dwen together resolves to a write.
          we_d    = (pick == PORT_D) && dwen;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (we_q) begin
          // Writes complete in ACCESS itself.
          last_d  = port_q;
          state_d = ST_IDLE;
        end else if (RD_LAT == 1) begin
          state_d = ST_RESP;
        end else begin
          cnt_d   = LAT_INIT;
          state_d = ST_LATWAIT;
        end
      end
      ST_LATWAIT: begin
        // Leave as the count reaches zero so RESP lines up with the
        // SRAM data, RD_LAT cycles after the ACCESS strobe.
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) state_d = ST_RESP;
      end
      ST_RESP: begin
        last_d  = port_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic. SRAM side only ever sees latched values; the wait flags
  // follow the live request except in the owning port's completion cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    sram_address = addr_q;
    sram_w_data  = wdata_q;
    sram_ren     = 1'b0;
    sram_wen     = 1'b0;
    iwait        = iren;
    dwait        = dreq;
    iload        = '0;
    dload        = '0;
    unique case (state_q)
      ST_ACCESS: begin
        if (we_q) begin
          sram_wen = 1'b1;
          dwait    = 1'b0;
        end else begin
          sram_ren = 1'b1;
        end
      end
      ST_RESP: begin
        if (port_q == PORT_D) begin
          dload = sram_r_data;
          dwait = 1'b0;
        end else begin
          iload = sram_r_data;
          iwait = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dyt_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dyt_sram_arbiter
//   Directed bench. Two arbiters share one stimulus: u_dut1 (RD_LAT=1) and
//   u_dut3 (RD_LAT=3), each with its own SRAM model that returns data exactly
//   RD_LAT cycles after sram_ren and a poison value at any other time.
//   Inputs are driven just after the falling edge; outputs are sampled 1ns
//   later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_dyt_sram_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        iren, dren, dwen;
  logic [31:0] iaddr, daddr, dstore;

  logic        iwait1, dwait1, ren1, wen1;
  logic [31:0] iload1, dload1, addr1, wd1, rdata1;
  logic        iwait3, dwait3, ren3, wen3;
  logic [31:0] iload3, dload3, addr3, wd3, rdata3;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [31:0] POISON = 32'hBAD0_0001;

  dyt_sram_arbiter #(.RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .iren(iren), .iaddr(iaddr), .iwait(iwait1), .iload(iload1),
    .dren(dren), .dwen(dwen), .daddr(daddr), .dstore(dstore),
    .dwait(dwait1), .dload(dload1),
    .sram_address(addr1), .sram_w_data(wd1),
    .sram_ren(ren1), .sram_wen(wen1), .sram_r_data(rdata1)
  );

  dyt_sram_arbiter #(.RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .iren(iren), .iaddr(iaddr), .iwait(iwait3), .iload(iload3),
    .dren(dren), .dwen(dwen), .daddr(daddr), .dstore(dstore),
    .dwait(dwait3), .dload(dload3),
    .sram_address(addr3), .sram_w_data(wd3),
    .sram_ren(ren3), .sram_wen(wen3), .sram_r_data(rdata3)
  );

  // Power-up contents of the SRAM models.
  function automatic logic [31:0] init_val(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h1111_0000;
      32'h0000_0100: return 32'hDEAD_BEEF;
      32'h0000_0200: return 32'hD0D0_0200;
      32'h0000_0300: return 32'hA5A5_5A5A;
      default:       return {16'hC0DE, a[15:0]};
    endcase
  endfunction

  // SRAM model, latency 1
  logic [31:0] mem1 [0:255];
  bit   [255:0] wv1;
  logic [31:0] p1;
  bit          v1;
  always @(posedge clk) begin
    v1 <= ren1;
    if (ren1) p1 <= wv1[addr1[9:2]] ? mem1[addr1[9:2]] : init_val(addr1);
    if (wen1) begin
      mem1[addr1[9:2]] <= wd1;
      wv1[addr1[9:2]]  <= 1'b1;
    end
  end
  assign rdata1 = v1 ? p1 : POISON;

  // SRAM model, latency 3
  logic [31:0] mem3 [0:255];
  bit   [255:0] wv3;
  logic [31:0] q3 [0:2];
  bit   [2:0]  v3;
  always @(posedge clk) begin
    v3    <= {v3[1:0], ren3};
    q3[0] <= wv3[addr3[9:2]] ? mem3[addr3[9:2]] : init_val(addr3);
    q3[1] <= q3[0];
    q3[2] <= q3[1];
    if (wen3) begin
      mem3[addr3[9:2]] <= wd3;
      wv3[addr3[9:2]]  <= 1'b1;
    end
  end
  assign rdata3 = v3[2] ? q3[2] : POISON;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Leaves the bench just after a falling edge with rst low and all
  // requests idle; the caller drives cycle 0 of its test from there.
  task automatic do_reset();
    rst = 1'b1; iren = 1'b0; dren = 1'b0; dwen = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    // ---------------- reset state + single fetch (RD_LAT=1) ----------------
    do_reset();
    #1;
    chk("rst_iwait", 32'(iwait1), 32'd0);
    chk("rst_dwait", 32'(dwait1), 32'd0);
    chk("rst_ren",   32'(ren1),   32'd0);
    chk("rst_wen",   32'(wen1),   32'd0);
    chk("rst_iload", iload1,      32'd0);
    chk("rst_dload", dload1,      32'd0);
    chk("rst_ren3",  32'(ren3),   32'd0);

    iren = 1'b1; iaddr = 32'h100;
    #1;
    chk("f_c0_iwait", 32'(iwait1), 32'd1);
    chk("f_c0_ren",   32'(ren1),   32'd0);
    step(); #1;
    chk("f_c1_ren",   32'(ren1),   32'd1);
    chk("f_c1_wen",   32'(wen1),   32'd0);
    chk("f_c1_addr",  addr1,       32'h100);
    chk("f_c1_iwait", 32'(iwait1), 32'd1);
    chk("f_c1_iload", iload1,      32'd0);
    step(); #1;
    chk("f_c2_iwait", 32'(iwait1), 32'd0);
    chk("f_c2_iload", iload1,      32'hDEAD_BEEF);
    chk("f_c2_ren",   32'(ren1),   32'd0);
    chk("f_c2_dwait", 32'(dwait1), 32'd0);
    step(); iren = 1'b0; #1;
    chk("f_c3_iwait", 32'(iwait1), 32'd0);
    chk("f_c3_iload", iload1,      32'd0);

    // ---------------- contention: data first, then alternate --------------
    do_reset();
    iren = 1'b1; dren = 1'b1; iaddr = 32'h0; daddr = 32'h200;
    #1;
    chk("arb_c0_iwait", 32'(iwait1), 32'd1);
    chk("arb_c0_dwait", 32'(dwait1), 32'd1);
    for (int k = 0; k < 20; k++) begin
      step(); #1;
      chk("arb_acc_addr", addr1, (k % 2 == 0) ? 32'h200 : 32'h0);
      chk("arb_acc_ren",  32'(ren1), 32'd1);
      step(); #1;
      if (k % 2 == 0) begin
        chk("arb_d_dwait", 32'(dwait1), 32'd0);
        chk("arb_d_dload", dload1,      32'hD0D0_0200);
        chk("arb_d_iwait", 32'(iwait1), 32'd1);
      end else begin
        chk("arb_i_iwait", 32'(iwait1), 32'd0);
        chk("arb_i_iload", iload1,      32'h1111_0000);
        chk("arb_i_dwait", 32'(dwait1), 32'd1);
      end
      step(); #1;
      chk("arb_idle_ren", 32'(ren1), 32'd0);
    end
    iren = 1'b0; dren = 1'b0;

    // ---------------- single write ----------------------------------------
    do_reset();
    dwen = 1'b1; daddr = 32'h40; dstore = 32'h1234_5678;
    #1;
    chk("w_c0_dwait", 32'(dwait1), 32'd1);
    chk("w_c0_wen",   32'(wen1),   32'd0);
    step(); #1;
    chk("w_c1_wen",   32'(wen1),   32'd1);
    chk("w_c1_ren",   32'(ren1),   32'd0);
    chk("w_c1_addr",  addr1,       32'h40);
    chk("w_c1_wdata", wd1,         32'h1234_5678);
    chk("w_c1_dwait", 32'(dwait1), 32'd0);
    step(); dwen = 1'b0; #1;
    chk("w_c2_wen",   32'(wen1),   32'd0);
    chk("w_c2_dwait", 32'(dwait1), 32'd0);

    // ---------------- dren+dwen is a write; then read it back -------------
    do_reset();
    dren = 1'b1; dwen = 1'b1; daddr = 32'h80; dstore = 32'hCAFE_F00D;
    #1;
    chk("rw_c0_ren",   32'(ren1),   32'd0);
    step(); #1;
    chk("rw_c1_wen",   32'(wen1),   32'd1);
    chk("rw_c1_ren",   32'(ren1),   32'd0);
    chk("rw_c1_dwait", 32'(dwait1), 32'd0);
    chk("rw_c1_wdata", wd1,         32'hCAFE_F00D);
    step(); dwen = 1'b0; #1;
    chk("rb_c0_ren",   32'(ren1),   32'd0);
    chk("rb_c0_dwait", 32'(dwait1), 32'd1);
    step(); #1;
    chk("rb_c1_ren",   32'(ren1),   32'd1);
    chk("rb_c1_addr",  addr1,       32'h80);
    step(); #1;
    chk("rb_c2_dwait", 32'(dwait1), 32'd0);
    chk("rb_c2_dload", dload1,      32'hCAFE_F00D);
    step(); dren = 1'b0; #1;
    chk("rb_c3_dload", dload1,      32'd0);

    // ---------------- RD_LAT=3 read ---------------------------------------
    do_reset();
    dren = 1'b1; daddr = 32'h300;
    #1;
    chk("l3_c0_dwait", 32'(dwait3), 32'd1);
    step(); #1;
    chk("l3_c1_ren",   32'(ren3),   32'd1);
    chk("l3_c1_wen",   32'(wen3),   32'd0);
    chk("l3_c1_addr",  addr3,       32'h300);
    step(); #1;
    chk("l3_c2_ren",   32'(ren3),   32'd0);
    chk("l3_c2_dwait", 32'(dwait3), 32'd1);
    step(); #1;
    chk("l3_c3_dwait", 32'(dwait3), 32'd1);
    chk("l3_c3_dload", dload3,      32'd0);
    step(); #1;
    chk("l3_c4_dwait", 32'(dwait3), 32'd0);
    chk("l3_c4_dload", dload3,      32'hA5A5_5A5A);
    step(); dren = 1'b0; #1;
    chk("l3_c5_dload", dload3,      32'd0);
    chk("l3_c5_dwait", 32'(dwait3), 32'd0);

    // ---------------- reset during LATWAIT aborts, fresh read completes ---
    do_reset();
    dren = 1'b1; daddr = 32'h300;
    step(); #1;
    chk("ab_c1_ren",   32'(ren3),   32'd1);
    step(); rst = 1'b1; #1;
    chk("ab_c2_dwait", 32'(dwait3), 32'd1);
    step(); rst = 1'b0; #1;
    chk("ab_c3_dwait", 32'(dwait3), 32'd1);
    chk("ab_c3_ren",   32'(ren3),   32'd0);
    step(); #1;
    chk("ab_c4_ren",   32'(ren3),   32'd1);
    chk("ab_c4_dwait", 32'(dwait3), 32'd1);
    step(); #1;
    chk("ab_c5_dwait", 32'(dwait3), 32'd1);
    step(); #1;
    chk("ab_c6_dwait", 32'(dwait3), 32'd1);
    step(); #1;
    chk("ab_c7_dwait", 32'(dwait3), 32'd0);
    chk("ab_c7_dload", dload3,      32'hA5A5_5A5A);
    step(); dren = 1'b0; #1;
    chk("ab_c8_dwait", 32'(dwait3), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
